prog_loader: RTL

//  Upstream feeder for the 256x8 program RAM. Accepts a framed byte stream
//  (valid/ready, e.g. from a UART receiver), asserts program_mode while the

---
 rtl/prog_loader_pkg.sv | 46 ++++
 rtl/prog_loader_timeout.sv | 38 +++
 rtl/prog_loader.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_pkg
// Brief   : Shared state encoding, frame layout and helpers for prog_loader.
// Revision: 1.0 - initial release
// ============================================================================
package prog_loader_pkg;

    typedef enum logic [2:0] {
        S_SYNC = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_MAR  = 3'd4,
        S_WE   = 3'd5,
        S_CHK  = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    localparam logic [7:0] C_SYNC_BYTE = 8'hA5;

    // Order in which the host tool emits frame fields; DATA repeats LEN times.
    typedef enum logic [2:0] {
        F_SYNC = 3'd0,
        F_ADDR = 3'd1,
        F_LEN  = 3'd2,
        F_DATA = 3'd3,
        F_CHK  = 3'd4
    } frame_field_t;

    // States that wait on the byte stream and are subject to the idle timeout.
    function automatic logic is_wait_state(input state_t s);
        return (s == S_ADDR) || (s == S_LEN) || (s == S_DATA) || (s == S_CHK);
    endfunction

    function automatic logic is_ready_state(input state_t s);
        return (s == S_SYNC) || is_wait_state(s);
    endfunction

    // A LEN field of zero encodes a full 256-byte page.
    function automatic logic [8:0] len_to_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_timeout.sv
`default_nettype none
// ============================================================================
// Module  : loader_timeout
// Brief   : Idle-cycle counter with clear/enable; flags the last idle cycle.
// Revision: 1.0 - initial release
// ============================================================================
module loader_timeout
    import prog_loader_pkg::*;
#(
    parameter int              TO_W    = 16,
    parameter logic [TO_W-1:0] TIMEOUT = 16'd50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TO_W-1:0] C_LAST = TIMEOUT - TO_W'(1);

    logic [TO_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + TO_W'(1);
        end
    end

    // Fires during the TIMEOUT-th consecutive idle cycle so the FSM leaves on that edge.
    assign expire = en & ~clr & (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Brief   : Framed byte-stream loader for the 256x8 program RAM with checksum.
// Revision: 1.0 - initial release
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]      SYNC_BYTE = C_SYNC_BYTE,
    parameter int              TO_W      = 16,
    parameter logic [TO_W-1:0] TIMEOUT   = 16'd50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       program_mode,
    output logic       pm_mar_wr,
    output logic [7:0] pm_mar_in,
    output logic       pm_we,
    output logic [7:0] pm_data,
    output logic       done,
    output logic       err,
    output logic       busy
);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_ptr;
    logic [7:0] r_sum;
    logic [7:0] r_hold;
    logic [7:0] r_mar_in;
    logic [8:0] r_cnt;
    logic       r_to_err;
    logic       w_accept;
    logic       w_wait;
    logic       w_expire;

    // Gated by rst_n so the stream sees not-ready while reset is held.
    assign in_ready = rst_n & is_ready_state(r_state);
    assign w_accept = in_valid & in_ready;
    assign w_wait   = is_wait_state(r_state);

    loader_timeout #(
        .TO_W    (TO_W),
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (w_accept),
        .en     (w_wait & ~w_accept),
        .expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_SYNC;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        program_mode = 1'b0;
        pm_mar_wr    = 1'b0;
        pm_we        = 1'b0;
        pm_data      = 8'h00;
        done         = 1'b0;
        err          = 1'b0;
        case (r_state)
            S_SYNC: begin
                if (w_accept && (in_data == SYNC_BYTE)) begin
                    w_next = S_ADDR;
                end
            end
            S_ADDR: begin
                program_mode = 1'b1;
                if (w_accept) begin
                    w_next = S_LEN;
                end else if (w_expire) begin
                    w_next = S_FIN;
                end
            end
            S_LEN: begin
                program_mode = 1'b1;
                if (w_accept) begin
                    w_next = S_DATA;
                end else if (w_expire) begin
                    w_next = S_FIN;
                end
            end
            S_DATA: begin
                program_mode = 1'b1;
                if (w_accept) begin
                    w_next = S_MAR;
                end else if (w_expire) begin
                    w_next = S_FIN;
                end
            end
            S_MAR: begin
                program_mode = 1'b1;
                pm_mar_wr    = 1'b1;
                w_next       = S_WE;
            end
            S_WE: begin
                program_mode = 1'b1;
                pm_we        = 1'b1;
                pm_data      = r_hold;
                w_next       = (r_cnt == 9'd1) ? S_CHK : S_DATA;
            end
            S_CHK: begin
                program_mode = 1'b1;
                if (w_accept || w_expire) begin
                    w_next = S_FIN;
                end
            end
            S_FIN: begin
                done   = ~r_to_err & (r_sum == 8'd0);
                err    = r_to_err | (r_sum != 8'd0);
                w_next = S_SYNC;
            end
            default: begin
                w_next = S_SYNC;
            end
        endcase
    end

    assign busy      = program_mode;
    assign pm_mar_in = r_mar_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= 8'h00;
            r_sum    <= 8'h00;
            r_hold   <= 8'h00;
            r_mar_in <= 8'h00;
            r_cnt    <= 9'd0;
            r_to_err <= 1'b0;
        end else begin
            case (r_state)
                S_SYNC: begin
                    if (w_accept) begin
                        r_to_err <= 1'b0;
                    end
                end
                S_ADDR: begin
                    if (w_accept) begin
                        r_ptr <= in_data;
                        r_sum <= in_data;
                    end
                end
                S_LEN: begin
                    if (w_accept) begin
                        r_cnt <= len_to_count(in_data);
                        r_sum <= r_sum + in_data;
                    end
                end
                S_DATA: begin
                    // Address is staged here so it is stable for the whole MAR strobe.
                    if (w_accept) begin
                        r_hold   <= in_data;
                        r_sum    <= r_sum + in_data;
                        r_mar_in <= r_ptr;
                    end
                end
                S_WE: begin
                    r_ptr <= r_ptr + 8'd1;
                    r_cnt <= r_cnt - 9'd1;
                end
                S_CHK: begin
                    if (w_accept) begin
                        r_sum <= r_sum + in_data;
                    end
                end
                default: begin
                end
            endcase
            if (w_expire) begin
                r_to_err <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
